// File: rtl/regif2tlp_pkg.sv
// Shared definitions for the register-response to TLP transmit path:
// TLP field encodings, response codes, TRN remainder values and FSM states.
package regif2tlp_pkg;

    localparam logic [1:0]  FMT_3DW_DATA = 2'b10;
    localparam logic [1:0]  FMT_4DW_DATA = 2'b11;
    localparam logic [4:0]  TYPE_MEM     = 5'b00000;
    localparam logic [9:0]  TLP_LEN_DW   = 10'd2;

    localparam logic [31:0] RESP_ACK     = 32'h0000_0001;
    localparam logic [31:0] RESP_NACK    = 32'h0000_0002;

    localparam logic [7:0]  TREM_2DW     = 8'h00;
    localparam logic [7:0]  TREM_UPPER   = 8'h0F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_ARB,
        S_B0,
        S_B1,
        S_B2,
        S_WAIT_DROP
    } state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/regif2tlp_sync2.sv
// Two-flop level synchronizer for single-bit handshake signals crossing
// into the clk domain.
module regif2tlp_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regif2tlp.sv
// Wraps a 64-bit register-read response in a Memory Write TLP to a host
// buffer and sends it on the TRN TX interface, then acks the accessor.
module regif2tlp
    import regif2tlp_pkg::*;
#(
    parameter logic [7:0] TLP_TAG = 8'h00,
    parameter logic       ATTR_RO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_resp,
    output logic        snd_resp_ack,
    input  logic [63:0] resp,
    input  logic [63:0] resp_host_addr,
    input  logic [15:0] cfg_completer_id,
    input  logic        trn_lnk_up_n,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n,
    input  logic        my_trn,
    output logic        drv_trn
);

    state_t      r_state;
    logic [63:0] r_resp;
    logic [31:0] r_addr_hi;
    logic [29:0] r_addr_lo;
    logic        r_is4dw;
    logic        r_ack;
    logic        r_drv;
    logic        r_tsrc_rdy_n;
    logic        r_tsof_n;
    logic        r_teof_n;
    logic [63:0] r_td;
    logic [7:0]  r_trem_n;

    logic        w_snd_resp_s;
    logic        w_beat_ok;
    logic [31:0] w_dw0;
    logic [31:0] w_dw1;
    logic [31:0] w_d0;
    logic [31:0] w_d1;
    logic [63:0] w_b1;
    logic [63:0] w_b2;
    logic        w_unused;

    regif2tlp_sync2 u_sync_snd_resp (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (snd_resp),
        .o_q   (w_snd_resp_s)
    );

    // Buffer address is DW-aligned; the two low bits carry no information.
    assign w_unused = ^resp_host_addr[1:0];

    assign w_dw0 = {1'b0, (r_is4dw ? FMT_4DW_DATA : FMT_3DW_DATA), TYPE_MEM,
                    1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, ATTR_RO, 1'b0,
                    2'b00, TLP_LEN_DW};
    assign w_dw1 = {cfg_completer_id, TLP_TAG, 4'hF, 4'hF};
    assign w_d0  = bswap32(r_resp[31:0]);
    assign w_d1  = bswap32(r_resp[63:32]);
    assign w_b1  = r_is4dw ? {r_addr_hi, r_addr_lo, 2'b00}
                           : {r_addr_lo, 2'b00, w_d0};
    assign w_b2  = r_is4dw ? {w_d0, w_d1} : {w_d1, 32'h0000_0000};

    assign w_beat_ok = !r_tsrc_rdy_n && !trn_tdst_rdy_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_resp       <= '0;
            r_addr_hi    <= '0;
            r_addr_lo    <= '0;
            r_is4dw      <= 1'b0;
            r_ack        <= 1'b0;
            r_drv        <= 1'b0;
            r_tsrc_rdy_n <= 1'b1;
            r_tsof_n     <= 1'b1;
            r_teof_n     <= 1'b1;
            r_td         <= '0;
            r_trem_n     <= TREM_2DW;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_snd_resp_s && !trn_lnk_up_n)
                        r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_resp    <= resp;
                    r_addr_hi <= resp_host_addr[63:32];
                    r_addr_lo <= resp_host_addr[31:2];
                    r_is4dw   <= (resp_host_addr[63:32] != 32'h0000_0000);
                    r_state   <= trn_lnk_up_n ? S_IDLE : S_ARB;
                end
                S_ARB: begin
                    if (trn_lnk_up_n) begin
                        r_state <= S_IDLE;
                    end else if (my_trn) begin
                        r_drv        <= 1'b1;
                        r_tsrc_rdy_n <= 1'b0;
                        r_tsof_n     <= 1'b0;
                        r_teof_n     <= 1'b1;
                        r_td         <= {w_dw0, w_dw1};
                        r_trem_n     <= TREM_2DW;
                        r_state      <= S_B0;
                    end
                end
                S_B0: begin
                    if (w_beat_ok) begin
                        r_tsof_n <= 1'b1;
                        r_td     <= w_b1;
                        r_state  <= S_B1;
                    end
                end
                S_B1: begin
                    if (w_beat_ok) begin
                        r_teof_n <= 1'b0;
                        r_td     <= w_b2;
                        r_trem_n <= r_is4dw ? TREM_2DW : TREM_UPPER;
                        r_state  <= S_B2;
                    end
                end
                S_B2: begin
                    // Bus release and ack land on the same cycle.
                    if (w_beat_ok) begin
                        r_tsrc_rdy_n <= 1'b1;
                        r_teof_n     <= 1'b1;
                        r_drv        <= 1'b0;
                        r_ack        <= 1'b1;
                        r_state      <= S_WAIT_DROP;
                    end
                end
                S_WAIT_DROP: begin
                    if (!w_snd_resp_s) begin
                        r_ack   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign snd_resp_ack   = r_ack;
    assign drv_trn        = r_drv;
    assign trn_tsrc_rdy_n = r_tsrc_rdy_n;
    assign trn_tsof_n     = r_tsof_n;
    assign trn_teof_n     = r_teof_n;
    assign trn_td         = r_td;
    assign trn_trem_n     = r_trem_n;

endmodule

// File: tb/tb_regif2tlp.sv
// Self-checking bench for regif2tlp: directed and randomized responses
// compared against a byte-level reference model of the expected TLP frame.
module tb_regif2tlp;

    localparam logic [7:0] TB_TAG     = 8'h00;
    localparam logic       TB_ATTR_RO = 1'b0;

    logic        clk;
    logic        rst_n;
    logic        snd_resp;
    logic        snd_resp_ack;
    logic [63:0] resp;
    logic [63:0] resp_host_addr;
    logic [15:0] cfg_completer_id;
    logic        trn_lnk_up_n;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;
    logic        my_trn;
    logic        drv_trn;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] got_td [3];
    logic [7:0]  got_trem [3];
    logic [2:0]  got_sof_n;
    logic [2:0]  got_eof_n;
    logic [2:0]  got_drv;
    int          lat;

    regif2tlp #(
        .TLP_TAG (TB_TAG),
        .ATTR_RO (TB_ATTR_RO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .snd_resp         (snd_resp),
        .snd_resp_ack     (snd_resp_ack),
        .resp             (resp),
        .resp_host_addr   (resp_host_addr),
        .cfg_completer_id (cfg_completer_id),
        .trn_lnk_up_n     (trn_lnk_up_n),
        .trn_td           (trn_td),
        .trn_trem_n       (trn_trem_n),
        .trn_tsof_n       (trn_tsof_n),
        .trn_teof_n       (trn_teof_n),
        .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n   (trn_tdst_rdy_n),
        .my_trn           (my_trn),
        .drv_trn          (drv_trn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] swap_bytes(input logic [31:0] x);
        logic [31:0] y;
        y = 32'h0;
        for (int b = 0; b < 4; b++)
            y = y | (((x >> (8 * b)) & 32'hFF) << (8 * (3 - b)));
        return y;
    endfunction

    function automatic logic [63:0] mdl_beat(input int idx, input logic [63:0] addr,
                                             input logic [63:0] rsp, input logic [15:0] id);
        logic [31:0] hi, lo, dw0, dw1, d0, d1;
        logic [63:0] beat;
        bit four;
        hi   = addr[63:32];
        lo   = addr[31:0] & 32'hFFFF_FFFC;
        four = (hi != 32'h0);
        dw0  = (four ? 32'd3 : 32'd2) * 32'h2000_0000 + 32'(TB_ATTR_RO) * 32'h2000 + 32'd2;
        dw1  = 32'(id) * 32'h1_0000 + 32'(TB_TAG) * 32'h100 + 32'hFF;
        d0   = swap_bytes(rsp[31:0]);
        d1   = swap_bytes(rsp[63:32]);
        if (idx == 0)      beat = {dw0, dw1};
        else if (idx == 1) beat = four ? {hi, lo} : {lo, d0};
        else               beat = four ? {d0, d1} : {d1, 32'h0};
        return beat;
    endfunction

    // Plays TRN destination; optionally stalls beat B1 for stall_b1 cycles.
    task automatic get_frame(input int stall_b1);
        int nb, cyc, stall_left;
        logic [63:0] held;
        bit held_v;
        nb = 0; cyc = 0; stall_left = stall_b1; held_v = 0; held = '0; lat = -1;
        trn_tdst_rdy_n = 1'b0;
        while (nb < 3 && cyc < 300) begin
            if (!trn_tsrc_rdy_n) begin
                if (lat < 0) lat = cyc;
                if (nb == 1 && stall_left > 0) begin
                    trn_tdst_rdy_n = 1'b1;
                    stall_left--;
                    if (!held_v) begin
                        held = trn_td; held_v = 1;
                    end else begin
                        check("stall_hold", trn_td, held);
                    end
                end else begin
                    trn_tdst_rdy_n = 1'b0;
                    got_td[nb]    = trn_td;
                    got_trem[nb]  = trn_trem_n;
                    got_sof_n[nb] = trn_tsof_n;
                    got_eof_n[nb] = trn_teof_n;
                    got_drv[nb]   = drv_trn;
                    if (held_v && nb == 1) check("stall_same", trn_td, held);
                    nb++;
                end
            end
            tick();
            cyc++;
        end
        trn_tdst_rdy_n = 1'b0;
        check("frame_done", 64'(nb), 64'd3);
    endtask

    task automatic check_frame(input string tag, input logic [63:0] addr,
                               input logic [63:0] rsp, input logic [15:0] id);
        for (int i = 0; i < 3; i++)
            check($sformatf("%s_b%0d", tag, i), got_td[i], mdl_beat(i, addr, rsp, id));
        check({tag, "_trem"}, 64'(got_trem[2]), (addr[63:32] != 32'h0) ? 64'h00 : 64'h0F);
        check({tag, "_sof"}, 64'(got_sof_n), 64'b110);
        check({tag, "_eof"}, 64'(got_eof_n), 64'b011);
        check({tag, "_drv"}, 64'(got_drv), 64'b111);
        check({tag, "_post"}, {61'b0, trn_tsrc_rdy_n, drv_trn, snd_resp_ack}, 64'b101);
    endtask

    task automatic finish_handshake(input string tag);
        snd_resp = 1'b0;
        tick(); tick();
        check({tag, "_ack_hold"}, 64'(snd_resp_ack), 64'd1);
        tick();
        check({tag, "_ack_fall"}, 64'(snd_resp_ack), 64'd0);
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a[31:0]  = $urandom;
        a[63:32] = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'h0;
        return a;
    endfunction

    initial begin
        bit bad;
        int cnt;

        rst_n = 1'b0; snd_resp = 1'b0; resp = '0; resp_host_addr = '0;
        cfg_completer_id = 16'h0100; trn_lnk_up_n = 1'b0; trn_tdst_rdy_n = 1'b0; my_trn = 1'b1;
        tick(); tick(); tick();
        check("rst_flags", {59'b0, snd_resp_ack, drv_trn, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}, 64'b00111);
        check("rst_td", trn_td, 64'h0);
        check("rst_trem", 64'(trn_trem_n), 64'h00);
        rst_n = 1'b1;
        tick(); tick();

        // 3DW directed vector
        resp_host_addr = 64'h0000_0000_1234_5670;
        resp = 64'h0000_0001_DEAD_BEEF;
        snd_resp = 1'b1;
        get_frame(0);
        check("lat3dw", 64'(lat), 64'd5);
        check("v3_b0", got_td[0], 64'h4000_0002_0100_00FF);
        check("v3_b1", got_td[1], 64'h1234_5670_EFBE_ADDE);
        check("v3_b2", got_td[2], 64'h0100_0000_0000_0000);
        check_frame("d3", resp_host_addr, resp, cfg_completer_id);
        finish_handshake("d3");

        // 4DW directed vector
        resp_host_addr = 64'h0000_0001_0000_0008;
        resp = {32'h0000_0002, 32'($urandom)};
        snd_resp = 1'b1;
        get_frame(0);
        check("v4_dw0", 64'(got_td[0][63:32]), 64'h6000_0002);
        check("v4_b1", got_td[1], 64'h0000_0001_0000_0008);
        check_frame("d4", resp_host_addr, resp, cfg_completer_id);
        finish_handshake("d4");

        // Backpressure on B1
        resp_host_addr = rand_addr();
        resp = {32'h0000_0001, 32'($urandom)};
        snd_resp = 1'b1;
        get_frame(3);
        check_frame("bp", resp_host_addr, resp, cfg_completer_id);
        finish_handshake("bp");

        // Grant delay, then request held long after ack
        my_trn = 1'b0;
        resp_host_addr = rand_addr();
        resp = {32'h0000_0002, 32'($urandom)};
        cfg_completer_id = 16'($urandom);
        snd_resp = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (drv_trn !== 1'b0 || trn_tsrc_rdy_n !== 1'b1) bad = 1;
        end
        check("no_grant_idle", 64'(bad), 64'd0);
        my_trn = 1'b1;
        get_frame(0);
        check_frame("gd", resp_host_addr, resp, cfg_completer_id);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (snd_resp_ack !== 1'b1 || trn_tsrc_rdy_n !== 1'b1) bad = 1;
        end
        check("single_frame", 64'(bad), 64'd0);
        finish_handshake("gd");

        // Back-to-back randomized requests
        for (int n = 0; n < 6; n++) begin
            resp_host_addr = rand_addr();
            resp = {($urandom_range(0, 1) == 1) ? 32'h1 : 32'h2, 32'($urandom)};
            cfg_completer_id = 16'($urandom);
            snd_resp = 1'b1;
            get_frame(int'($urandom_range(0, 3)));
            check_frame($sformatf("bb%0d", n), resp_host_addr, resp, cfg_completer_id);
            finish_handshake($sformatf("bb%0d", n));
        end

        // Reset while B1 is on the bus
        resp_host_addr = rand_addr();
        resp = {32'h1, 32'($urandom)};
        snd_resp = 1'b1;
        trn_tdst_rdy_n = 1'b0;
        cnt = 0;
        while (trn_tsrc_rdy_n !== 1'b0 && cnt < 20) begin tick(); cnt++; end
        tick();
        check("in_b1", {62'b0, trn_tsrc_rdy_n, trn_tsof_n}, 64'b01);
        rst_n = 1'b0;
        snd_resp = 1'b0;
        tick();
        check("mid_rst_flags", {59'b0, snd_resp_ack, drv_trn, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}, 64'b00111);
        check("mid_rst_td", trn_td, 64'h0);
        check("mid_rst_trem", 64'(trn_trem_n), 64'h00);
        rst_n = 1'b1;
        tick(); tick(); tick();

        // Link drop while waiting for the grant
        my_trn = 1'b0;
        resp_host_addr = rand_addr();
        resp = {32'h2, 32'($urandom)};
        snd_resp = 1'b1;
        tick(); tick(); tick(); tick();
        trn_lnk_up_n = 1'b1;
        tick();
        my_trn = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (snd_resp_ack !== 1'b0 || trn_tsrc_rdy_n !== 1'b1 || drv_trn !== 1'b0) bad = 1;
        end
        check("link_down_quiet", 64'(bad), 64'd0);
        trn_lnk_up_n = 1'b0;
        get_frame(0);
        check_frame("lk", resp_host_addr, resp, cfg_completer_id);
        finish_handshake("lk");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
